// File: rtl/unified_mem_pkg.sv
// Shared definitions for the unified instruction/data memory and the core
// that drives it: bus command encoding, default depth and tag width.
package mem_pkg;

  // Default depth in 32-bit words (64 KiB).
  localparam int MEM_WORDS = 16384;

  // Default width of the response/tag fields.
  localparam int TAG_W = 4;

  // Bus command encoding; the fourth code (2'd3) is reserved and behaves as BUS_NONE.
  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  // True for the two commands that perform a memory transaction.
  function automatic logic is_mem_op(input logic [1:0] command);
    logic result;
    case (command)
      BUS_LOAD:  result = 1'b1;
      BUS_STORE: result = 1'b1;
      default:   result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/unified_mem_if.sv
// Processor-to-memory bus: byte address, store data and command in one
// direction; response tag, load data and completion tag in the other.
interface unified_mem_if #(
  parameter int TAG_W = mem_pkg::TAG_W
);

  logic [31:0]      proc2mem_addr;
  logic [31:0]      proc2mem_data;
  logic [1:0]       proc2mem_command;
  logic [TAG_W-1:0] mem2proc_response;
  logic [31:0]      mem2proc_data;
  logic [TAG_W-1:0] mem2proc_tag;

  // Processor side: issues commands, receives data and tags.
  modport master (
    output proc2mem_addr,
    output proc2mem_data,
    output proc2mem_command,
    input  mem2proc_response,
    input  mem2proc_data,
    input  mem2proc_tag
  );

  // Memory side: receives commands, returns data and tags.
  modport slave (
    input  proc2mem_addr,
    input  proc2mem_data,
    input  proc2mem_command,
    output mem2proc_response,
    output mem2proc_data,
    output mem2proc_tag
  );

endinterface

// File: rtl/unified_mem.sv
// Unified word memory used for both instruction fetch and data access.
// Loads return data in the same cycle; stores commit on the rising edge.
// Every accepted command is tagged with a non-zero counter value, so a tag
// of 0 on the bus always means "nothing happened this cycle".
module unified_mem
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = mem_pkg::MEM_WORDS,
  parameter int TAG_W     = mem_pkg::TAG_W
) (
  input  logic          clk,
  input  logic          rst,
  unified_mem_if.slave  bus
);

  localparam int               IDX_W     = $clog2(MEM_WORDS);
  localparam logic [32:0]      MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
  localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(1);
  localparam logic [TAG_W-1:0] TAG_LAST  = {TAG_W{1'b1}};

  // Next tag value: count up and wrap past zero, which is reserved for "none".
  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] cur);
    logic [TAG_W-1:0] nxt;
    if (cur == TAG_LAST) begin
      nxt = TAG_FIRST;
    end else begin
      nxt = cur + TAG_W'(1);
    end
    return nxt;
  endfunction

  // Backing store; preloaded by the simulation environment, never cleared by reset.
  logic [31:0] unified_memory [MEM_WORDS];

  logic [TAG_W-1:0] tag_r;
  logic [IDX_W-1:0] index_s;
  logic             in_range_s;
  logic             is_load_s;
  logic             is_store_s;
  logic             accept_s;
  logic             store_s;

  // Decode the command: word index, range check, and whether it is accepted.
  always_comb begin
    index_s    = bus.proc2mem_addr[IDX_W+1:2];
    in_range_s = ({1'b0, bus.proc2mem_addr} < MEM_BYTES);
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    case (bus.proc2mem_command)
      BUS_LOAD:  is_load_s  = 1'b1;
      BUS_STORE: is_store_s = 1'b1;
      default: begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
      end
    endcase
    if (rst && in_range_s && is_mem_op(bus.proc2mem_command)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    store_s = accept_s & is_store_s;
  end

  // Drive the response side: tag on any accepted command, data only on loads.
  always_comb begin
    bus.mem2proc_response = '0;
    bus.mem2proc_tag      = '0;
    bus.mem2proc_data     = 32'd0;
    if (accept_s) begin
      bus.mem2proc_response = tag_r;
      bus.mem2proc_tag      = tag_r;
      if (is_load_s) begin
        bus.mem2proc_data = unified_memory[index_s];
      end else begin
        bus.mem2proc_data = 32'd0;
      end
    end else begin
      bus.mem2proc_response = '0;
      bus.mem2proc_tag      = '0;
      bus.mem2proc_data     = 32'd0;
    end
  end

  // Tag counter: restarts at 1 on reset and advances once per accepted command.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_r <= TAG_FIRST;
    end else if (accept_s) begin
      tag_r <= next_tag(tag_r);
    end else begin
      tag_r <= tag_r;
    end
  end

  // Store commit; accept_s already excludes reset and out-of-range addresses.
  always_ff @(posedge clk) begin
    if (store_s) begin
      unified_memory[index_s] <= bus.proc2mem_data;
    end
  end

endmodule

// File: tb/tb_unified_mem.sv
// Directed bench for unified_mem: each step drives one command, pushes the
// expected response into a scoreboard queue, then pops it and compares
// against the combinational outputs mid-cycle, before the commit edge.
module tb_unified_mem;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;

  unified_mem_if bus_if ();

  unified_mem dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // One comparison: count it, and on mismatch count and report it.
  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  // Drive one command at the falling edge and check the same-cycle response.
  // exp_tg = 0 means the command must not be accepted (all outputs zero).
  task automatic step(input string name, input logic rst_v, input logic [1:0] cmd,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] exp_tg, input logic [31:0] exp_data);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst                     = rst_v;
    bus_if.proc2mem_command = cmd;
    bus_if.proc2mem_addr    = addr;
    bus_if.proc2mem_data    = wdata;
    e.name = name;
    e.resp = exp_tg;
    e.tag  = exp_tg;
    e.data = exp_data;
    sb_q.push_back(e);
    #2;
    got = sb_q.pop_front();
    check({got.name, ".resp"}, {28'd0, bus_if.mem2proc_response}, {28'd0, got.resp});
    check({got.name, ".tag"},  {28'd0, bus_if.mem2proc_tag},      {28'd0, got.tag});
    check({got.name, ".data"}, bus_if.mem2proc_data,              got.data);
  endtask

  initial begin
    rst                     = 1'b0;
    bus_if.proc2mem_command = 2'd0;
    bus_if.proc2mem_addr    = 32'd0;
    bus_if.proc2mem_data    = 32'd0;

    // Preload selected words.
    dut.unified_memory[0]  = 32'hA5A5_0000;
    dut.unified_memory[16] = 32'hDEAD_BEEF;
    dut.unified_memory[32] = 32'h0BAD_F00D;

    // Held in reset: commands ignored, outputs zero, store suppressed.
    step("rst_load",  1'b0, BUS_LOAD,  32'h0000_0040, 32'd0,          4'd0, 32'd0);
    step("rst_store", 1'b0, BUS_STORE, 32'h0000_0040, 32'h1111_1111,  4'd0, 32'd0);

    // Basic load and read-after-write.
    step("load_40",    1'b1, BUS_LOAD,  32'h0000_0040, 32'd0,          4'd1, 32'hDEAD_BEEF);
    step("store_100",  1'b1, BUS_STORE, 32'h0000_0100, 32'h1234_5678,  4'd2, 32'd0);
    step("load_100",   1'b1, BUS_LOAD,  32'h0000_0100, 32'd0,          4'd3, 32'h1234_5678);
    step("load_103",   1'b1, BUS_LOAD,  32'h0000_0103, 32'd0,          4'd4, 32'h1234_5678);

    // Idle and reserved cycles between loads do not consume tags.
    step("none_a",     1'b1, BUS_NONE,  32'h0000_0040, 32'd0,          4'd0, 32'd0);
    step("load_40b",   1'b1, BUS_LOAD,  32'h0000_0040, 32'd0,          4'd5, 32'hDEAD_BEEF);
    step("none_b",     1'b1, BUS_NONE,  32'h0000_0040, 32'd0,          4'd0, 32'd0);
    step("rsvd_a",     1'b1, 2'd3,      32'h0000_0040, 32'd0,          4'd0, 32'd0);
    step("load_100b",  1'b1, BUS_LOAD,  32'h0000_0100, 32'd0,          4'd6, 32'h1234_5678);

    // Out of range and reserved commands: rejected and no write.
    step("oor_load",   1'b1, BUS_LOAD,  32'h0004_0000, 32'd0,          4'd0, 32'd0);
    step("oor_store",  1'b1, BUS_STORE, 32'h0004_0000, 32'hFFFF_FFFF,  4'd0, 32'd0);
    step("oor_edge",   1'b1, BUS_STORE, 32'h0001_0000, 32'hFFFF_FFFF,  4'd0, 32'd0);
    step("rsvd_st",    1'b1, 2'd3,      32'h0000_0000, 32'hFFFF_FFFF,  4'd0, 32'd0);
    step("load_0",     1'b1, BUS_LOAD,  32'h0000_0000, 32'd0,          4'd7, 32'hA5A5_0000);

    // Highest in-range word.
    step("store_top",  1'b1, BUS_STORE, 32'h0000_FFFC, 32'hCAFE_F00D,  4'd8, 32'd0);
    step("load_top",   1'b1, BUS_LOAD,  32'h0000_FFFF, 32'd0,          4'd9, 32'hCAFE_F00D);

    // Reset asserted during a store: word kept, tag restarts at 1.
    step("rst_st80",   1'b0, BUS_STORE, 32'h0000_0080, 32'hFFFF_FFFF,  4'd0, 32'd0);
    step("load_80",    1'b1, BUS_LOAD,  32'h0000_0080, 32'd0,          4'd1, 32'h0BAD_F00D);
    step("load_40c",   1'b1, BUS_LOAD,  32'h0000_0040, 32'd0,          4'd2, 32'hDEAD_BEEF);

    // Tag wrap: 16 loads after reset give 1..15 then 1, never 0.
    step("rst_wrap",   1'b0, BUS_NONE,  32'h0000_0000, 32'd0,          4'd0, 32'd0);
    for (int i = 0; i < 16; i++) begin
      step($sformatf("wrap_%0d", i), 1'b1, BUS_LOAD, 32'h0000_0040, 32'd0,
           4'((i % 15) + 1), 32'hDEAD_BEEF);
    end

    step("idle_end",   1'b1, BUS_NONE,  32'h0000_0000, 32'd0,          4'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
